// File: rtl/md_ctrl_pkg.sv
// Shared opcode, state and latency definitions for the multiply/divide sequencing control.
package md_ctrl_pkg;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_t;

  function automatic logic is_md_arith(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_lat_counter.sv
// Loadable down-counter timing the multiply/divide latency; last flags the final busy cycle.
module md_lat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         last
);

  always_ff @(posedge clk) begin
    if (reset)                  cnt <= '0;
    else if (clr)               cnt <= '0;
    else if (load)              cnt <= load_val;
    else if (en && cnt != '0)   cnt <= cnt - W'(1);
  end

  assign last = (cnt == W'(1));

endmodule

// File: rtl/md_seq_ctrl.sv
// E-stage multiply/divide sequencer: start/commit strobes, HI/LO move enables,
// D-stage stall and abort of a just-issued op on exception flush.
module md_seq_ctrl
  import md_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] op_E,
  input  logic       md_use_D,
  input  logic       exl_flush,
  output logic       start,
  output logic       busy,
  output logic       commit,
  output logic       hi_we,
  output logic       lo_we,
  output logic       is_div,
  output logic       stall_D
);

  localparam int CW = $clog2(DIV_CYCLES + 1);
  localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES);

  md_state_t         state, state_nxt;
  logic [CW-1:0]     cnt;
  logic              cnt_last;
  logic              abort;
  logic              first_cyc;

  // The issuing instruction sits in M only during the first busy cycle;
  // a flush then must kill the op, later flushes belong to younger instrs.
  assign first_cyc = (state == RUN) && (cnt == (is_div ? DIV_LD : MULT_LD));
  assign abort     = exl_flush && first_cyc;

  md_lat_counter #(.W(CW)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (start),
    .load_val (is_div_op(op_E) ? DIV_LD : MULT_LD),
    .en       (state == RUN),
    .clr      (abort),
    .cnt      (cnt),
    .last     (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      is_div <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start) is_div <= is_div_op(op_E);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN:  if (abort || cnt_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start   = (state == IDLE) && is_md_arith(op_E) && !exl_flush;
    busy    = (state == RUN);
    commit  = (state == RUN) && cnt_last && !abort;
    hi_we   = (op_E == MD_MTHI) && !exl_flush;
    lo_we   = (op_E == MD_MTLO) && !exl_flush;
    stall_D = md_use_D && (start || busy);
  end

endmodule

// File: tb/tb_md_seq_ctrl.sv
// Directed scoreboard bench: stimulus queues the hand-derived output vector per cycle,
// a negedge monitor pops and compares against the DUT.
module tb_md_seq_ctrl;
  import md_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] op_E;
  logic       md_use_D, exl_flush;
  logic       start, busy, commit, hi_we, lo_we, is_div, stall_D;

  // expected vector bit order: {start,busy,commit,hi_we,lo_we,is_div,stall_D}
  localparam logic [6:0] S = 7'h40, B = 7'h20, C = 7'h10, H = 7'h08,
                         L = 7'h04, DV = 7'h02, ST = 7'h01;
  localparam logic [6:0] ALL = 7'h7F, NODIV = 7'h7D;

  typedef struct {
    logic [6:0] ex;
    logic [6:0] mk;
    string      nm;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  md_seq_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .op_E      (op_E),
    .md_use_D  (md_use_D),
    .exl_flush (exl_flush),
    .start     (start),
    .busy      (busy),
    .commit    (commit),
    .hi_we     (hi_we),
    .lo_we     (lo_we),
    .is_div    (is_div),
    .stall_D   (stall_D)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [6:0] act;
      e   = q.pop_front();
      act = {start, busy, commit, hi_we, lo_we, is_div, stall_D};
      total++;
      if ((act & e.mk) !== (e.ex & e.mk)) begin
        bad++;
        $display("FAIL %s: got %b want %b (mask %b) t=%0t", e.nm, act, e.ex, e.mk, $time);
      end
    end
  end

  task automatic step(input logic [2:0] op, input logic use_d, input logic fl,
                      input logic rst, input logic [6:0] ex, input logic [6:0] mk,
                      input string nm);
    op_E = op; md_use_D = use_d; exl_flush = fl; reset = rst;
    q.push_back('{ex, mk, nm});
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; op_E = MD_NONE; md_use_D = 1'b0; exl_flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    step(MD_NONE, 0, 0, 0, 7'h00, ALL, "reset_state");
    step(MD_NONE, 1, 0, 0, 7'h00, ALL, "idle_use_no_stall");

    // MULT with dependent mflo in D
    step(MD_MULT, 1, 0, 0, S | ST, ALL, "mult_start");
    for (int i = 1; i <= 5; i++)
      step(MD_NONE, 1, 0, 0, B | ST | ((i == 5) ? C : 7'h00), ALL, $sformatf("mult_run%0d", i));
    step(MD_NONE, 1, 0, 0, 7'h00, ALL, "mult_done");

    // DIVU then back-to-back DIV
    step(MD_DIVU, 0, 0, 0, S, ALL, "divu_start");
    for (int i = 1; i <= 10; i++)
      step(MD_NONE, 0, 0, 0, B | DV | ((i == 10) ? C : 7'h00), ALL, $sformatf("divu_run%0d", i));
    step(MD_DIV, 0, 0, 0, S, NODIV, "div_b2b_start");
    for (int i = 1; i <= 10; i++)
      step(MD_NONE, 0, 0, 0, B | DV | ((i == 10) ? C : 7'h00), ALL, $sformatf("div_b2b_run%0d", i));
    step(MD_NONE, 0, 0, 0, 7'h00, NODIV, "div_b2b_done");

    // abort in first busy cycle
    step(MD_DIV, 0, 0, 0, S, NODIV, "abort_start");
    step(MD_NONE, 0, 1, 0, B | DV, ALL, "abort_flush");
    for (int i = 0; i < 10; i++)
      step(MD_NONE, 0, 0, 0, 7'h00, NODIV, $sformatf("abort_idle%0d", i));

    // late flush ignored
    step(MD_DIV, 0, 0, 0, S, NODIV, "lateflush_start");
    for (int i = 1; i <= 10; i++)
      step(MD_NONE, 0, (i == 4), 0, B | DV | ((i == 10) ? C : 7'h00), ALL, $sformatf("lateflush_run%0d", i));

    // HI/LO moves
    step(MD_MTHI, 0, 0, 0, H, NODIV, "mthi");
    step(MD_MTHI, 0, 1, 0, 7'h00, NODIV, "mthi_flush");
    step(MD_MTLO, 0, 0, 0, L, NODIV, "mtlo");
    step(MD_MTLO, 0, 1, 0, 7'h00, NODIV, "mtlo_flush");

    // flush in issue cycle suppresses start
    step(MD_MULT, 1, 1, 0, 7'h00, NODIV, "mult_flush_issue");
    step(MD_NONE, 1, 0, 0, 7'h00, NODIV, "mult_flush_nobusy");

    // synchronous reset mid-run
    step(MD_MULTU, 0, 0, 0, S, NODIV, "rst_start");
    step(MD_NONE, 0, 0, 0, B, ALL, "rst_run1");
    step(MD_NONE, 0, 0, 0, B, ALL, "rst_run2");
    step(MD_NONE, 0, 0, 1, B, ALL, "rst_run3_reset");
    for (int i = 0; i < 4; i++)
      step(MD_NONE, 1, 0, 0, 7'h00, ALL, $sformatf("rst_idle%0d", i));

    // MTHI appearing while RUN still writes
    step(MD_MULT, 1, 0, 0, S | ST, ALL, "mthi_run_start");
    step(MD_MTHI, 1, 0, 0, B | H | ST, ALL, "mthi_in_run");
    for (int i = 2; i <= 5; i++)
      step(MD_NONE, 1, 0, 0, B | ST | ((i == 5) ? C : 7'h00), ALL, $sformatf("mthi_run%0d", i));
    step(MD_NONE, 1, 0, 0, 7'h00, ALL, "mthi_run_done");

    @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/md_seq_ctrl.md
# md_seq_ctrl

Sequencing controller for the multiply/divide unit in the E stage of the 5-stage MIPS pipeline. Turns the E-stage MD opcode into a one-cycle start strobe, times the fixed mult/div latency with a down-counter, and emits a one-cycle commit strobe that copies the temp result into HI/LO. Also generates mthi/mtlo write enables, the D-stage stall for any MD-class instruction, and abort of a just-issued op on exception flush.

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu (≥2)
- DIV_CYCLES, 10, busy cycles for div/divu (≥2, ≥MULT_CYCLES)
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- op_E  in  3  E-stage MD opcode, codes from md_ctrl_pkg
- md_use_D  in  1  D-stage instr is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- exl_flush  in  1  exception/eret flush this cycle
- start  out  1  comb; datapath captures D1/D2 and computes temp result this edge
- busy  out  1  registered; op in flight
- commit  out  1  comb, one cycle; datapath loads HI/LO from temp this edge
- hi_we  out  1  comb; mthi write this edge
- lo_we  out  1  comb; mtlo write this edge
- is_div  out  1  registered; kind of op in flight (0 mult, 1 div)
- stall_D  out  1  comb; freeze F/D, bubble into E

## Operation
- States IDLE, RUN. Registers: state, cnt (width $clog2(DIV_CYCLES+1)), is_div.
- Reset: state=IDLE, cnt=0, is_div=0; busy=0, all strobes 0.
- start = (state==IDLE) && op_E∈{MULT,MULTU,DIV,DIVU} && !exl_flush.
- IDLE→RUN on start: cnt←MULT_CYCLES or DIV_CYCLES, is_div←(op is div/divu).
- RUN: cnt decrements each cycle; commit = (state==RUN) && (cnt==1) && !abort; RUN→IDLE when cnt==1.
- abort = exl_flush && state==RUN && cnt==loaded value (first busy cycle, issuing instr now in M). Abort → IDLE, cnt←0, no commit. exl_flush in any later RUN cycle is ignored (op already past M).
- busy = (state==RUN).
- hi_we = (op_E==MTHI) && !exl_flush; lo_we likewise for MTLO. Never asserted in RUN under legal operation (stall guarantees); if op_E is MTHI/MTLO in RUN, still assert (later commit overwrites, matches sequential program order).
- stall_D = md_use_D && (start || busy).
- start with op_E issued while RUN is not possible (stalled); if it occurs, ignore it.

## Timing
- start in cycle T → busy high T+1..T+N (N = MULT_CYCLES or DIV_CYCLES) → commit in T+N → busy low T+N+1.
- D-stage MD instr stalls T..T+N (N+1 cycles), reaches E in T+N+1 and reads new HI/LO.
- Back-to-back: new start allowed in T+N+1.
- Abort: exl_flush in T+1 → busy low from T+2, no commit, HI/LO unchanged.
- exl_flush in T suppresses start entirely; busy stays 0.
- reset mid-RUN: IDLE next cycle, no commit.

## Structure
- md_ctrl_pkg: opcode constants MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MTHI=5, MD_MTLO=6; state encoding IDLE=0, RUN=1; default latency constants.
- Sub-module md_lat_counter: loadable down-counter with load/en inputs and a last (cnt==1) flag; controller instantiates one.
- MD datapath keeps HI/LO/temp regs and arithmetic; this block holds only control.

## Test plan
- op_E=MULT one cycle at T, md_use_D=1 (mflo) → start@T, busy T+1..T+5, commit@T+5 only, stall_D T..T+5, low at T+6.
- op_E=DIVU at T → busy T+1..T+10, commit@T+10, is_div=1 T+1..T+10; second DIV at T+11 → start@T+11.
- DIV at T, exl_flush@T+1 → busy 0 from T+2, commit never asserts; exl_flush@T+4 instead → commit still @T+10.
- op_E=MTHI with exl_flush=0 → hi_we=1, busy 0; with exl_flush=1 → hi_we=0; MULT with exl_flush@T → start=0, busy stays 0.
- reset at T+3 of MULT → state IDLE, busy=0 at T+4, commit never asserts; md_use_D=1 with op_E=NONE in IDLE → stall_D=0.
